// File: rtl/cafe_pkg.sv
// -----------------------------------------------------------------------------
// cafe_pkg
//   Shared definitions for the cafe vending coin path.
//   - dispense_state_t : payout FSM states of coin_change_dispenser
//   - COIN*_VAL        : coin values in units of 100
//   - PRICE_*          : product prices (units of 100) used by the controller
//   - coin_fits()      : true when an owed amount can absorb one coin
// -----------------------------------------------------------------------------
package cafe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_EJECT,
    ST_GAP,
    ST_DONE,
    ST_FAULT
  } dispense_state_t;

  localparam int unsigned COIN500_VAL = 5;
  localparam int unsigned COIN100_VAL = 1;

  localparam int unsigned PRICE_COFFEE = 3;
  localparam int unsigned PRICE_TEA    = 2;
  localparam int unsigned PRICE_COCOA  = 4;
  localparam int unsigned PRICE_SOUP   = 6;

  // A coin may only be paid when it does not exceed the amount still owed,
  // so the unsigned remaining counter can never wrap.
  function automatic logic coin_fits(input int unsigned rem, input int unsigned coin);
    return rem >= coin;
  endfunction

endpackage

// File: rtl/dispense_timer.sv
// -----------------------------------------------------------------------------
// dispense_timer
//   Loadable down-counter of tick strobes, shared by the EJECT and GAP phases.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     load      : load load_val (has priority over tick)
//     load_val  : number of ticks to count (>=1)
//     tick      : 1-cycle timing enable
//     expired   : high on the tick that completes the loaded count
// -----------------------------------------------------------------------------
module dispense_timer #(
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          tick,
  output logic          expired
);

  logic [CW-1:0] r_count;

  // A tick coinciding with load is swallowed: counting starts after entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  // Expires on the tick that takes the count from 1 to 0.
  assign expired = tick && (r_count <= CW'(1));

endmodule

// File: rtl/coin_change_dispenser.sv
// -----------------------------------------------------------------------------
// coin_change_dispenser
//   Pays out change as paced coin-eject pulses, 500 coins first, falling back
//   to 100 coins when the 500 hopper is empty. Faults on an over-range amount
//   or when no hopper can pay the remainder; ack returns to idle.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     tick       : 1-cycle timing strobe pacing pulses and gaps
//     start      : payout request, sampled only in idle
//     amount     : change to pay (units of 100), latched on accepted start
//     empty500   : 500 hopper empty (sampled in CHECK only)
//     empty100   : 100 hopper empty (sampled in CHECK only)
//     ack        : clears a fault
//     eject500   : 500 ejector drive
//     eject100   : 100 ejector drive
//     busy       : high from accept through DONE (and in FAULT)
//     done       : 1-cycle payout-complete pulse
//     err        : high while faulted
//     remaining  : amount still owed
// -----------------------------------------------------------------------------
module coin_change_dispenser
  import cafe_pkg::*;
#(
  parameter int unsigned W           = 8,
  parameter int unsigned PULSE_TICKS = 1,
  parameter int unsigned GAP_TICKS   = 1,
  parameter int unsigned MAX_CHANGE  = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic         start,
  input  logic [W-1:0] amount,
  input  logic         empty500,
  input  logic         empty100,
  input  logic         ack,
  output logic         eject500,
  output logic         eject100,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] remaining
);

  localparam int unsigned TMAX = (PULSE_TICKS > GAP_TICKS) ? PULSE_TICKS : GAP_TICKS;
  localparam int unsigned CW   = $clog2(TMAX + 1);

  dispense_state_t r_state;
  dispense_state_t w_next;

  logic [W-1:0]  r_remaining;
  logic          r_sel500;
  logic          w_take500;
  logic          w_take100;
  logic          w_load;
  logic [CW-1:0] w_load_val;
  logic          w_expired;
  logic          w_over;
  logic          w_fit500;
  logic          w_fit100;

  assign w_over   = r_remaining > W'(MAX_CHANGE);
  assign w_fit500 = coin_fits(32'(r_remaining), COIN500_VAL);
  assign w_fit100 = coin_fits(32'(r_remaining), COIN100_VAL);

  dispense_timer #(
    .CW (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .tick     (tick),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the coin decision; the timer is loaded on the edge that
  // enters EJECT or GAP so each phase counts its ticks from zero.
  always_comb begin
    w_next     = r_state;
    w_take500  = 1'b0;
    w_take100  = 1'b0;
    w_load     = 1'b0;
    w_load_val = CW'(PULSE_TICKS);
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (w_over) begin
          w_next = ST_FAULT;
        end else if (r_remaining == '0) begin
          w_next = ST_DONE;
        end else if (w_fit500 && !empty500) begin
          w_next    = ST_EJECT;
          w_take500 = 1'b1;
          w_load    = 1'b1;
        end else if (w_fit100 && !empty100) begin
          w_next    = ST_EJECT;
          w_take100 = 1'b1;
          w_load    = 1'b1;
        end else begin
          w_next = ST_FAULT;
        end
      end
      ST_EJECT: begin
        if (w_expired) begin
          w_next     = ST_GAP;
          w_load     = 1'b1;
          w_load_val = CW'(GAP_TICKS);
        end
      end
      ST_GAP: begin
        if (w_expired) begin
          w_next = ST_CHECK;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (ack) begin
          w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Remaining is debited on the same edge the ejector line rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_remaining <= '0;
      r_sel500    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_remaining <= amount;
      end else if (w_take500) begin
        r_remaining <= r_remaining - W'(COIN500_VAL);
        r_sel500    <= 1'b1;
      end else if (w_take100) begin
        r_remaining <= r_remaining - W'(COIN100_VAL);
        r_sel500    <= 1'b0;
      end else if ((r_state == ST_DONE) || ((r_state == ST_FAULT) && ack)) begin
        r_remaining <= '0;
      end
    end
  end

  // Outputs decode the state register directly, so reset clears them at once.
  assign eject500  = (r_state == ST_EJECT) && r_sel500;
  assign eject100  = (r_state == ST_EJECT) && !r_sel500;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign err       = (r_state == ST_FAULT);
  assign remaining = r_remaining;

endmodule

// File: tb/tb_coin_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_coin_change_dispenser
//   Scoreboard bench: each scenario pushes the expected payout events (coin
//   kind and remaining after the debit, then the done pulse); a negedge
//   monitor pops and compares them as eject/done edges appear, and also checks
//   one-hot ejectors, pulse length in ticks and one-cycle done.
// -----------------------------------------------------------------------------
module tb_coin_change_dispenser;

  localparam int W     = 8;
  localparam int PT    = 2;
  localparam int GT    = 1;
  localparam int MAXC  = 11;
  localparam int LIMIT = 1000;

  localparam int K500  = 0;
  localparam int K100  = 1;
  localparam int KDONE = 2;

  logic         clk;
  logic         rst;
  logic         tick;
  logic         start;
  logic [W-1:0] amount;
  logic         empty500;
  logic         empty100;
  logic         ack;
  logic         eject500;
  logic         eject100;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] remaining;

  typedef struct {
    int kind;
    int rem;
  } ev_t;

  ev_t sb[$];
  int  checks   = 0;
  int  failures = 0;

  coin_change_dispenser #(
    .W           (W),
    .PULSE_TICKS (PT),
    .GAP_TICKS   (GT),
    .MAX_CHANGE  (MAXC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .start     (start),
    .amount    (amount),
    .empty500  (empty500),
    .empty100  (empty100),
    .ack       (ack),
    .eject500  (eject500),
    .eject100  (eject100),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .remaining (remaining)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick strobe: one full cycle high out of every four.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  // Monitor
  logic p500  = 1'b0;
  logic p100  = 1'b0;
  logic pdone = 1'b0;
  int   pulse_ticks = 0;
  int   ev_kind;
  ev_t  ev;

  always @(negedge clk) begin
    checks++;
    if (eject500 && eject100) begin
      failures++;
      $display("FAIL one_hot_eject: eject500=%0b eject100=%0b, required not both high", eject500, eject100);
    end
    if (!rst) begin
      ev_kind = -1;
      if (eject500 && !p500) ev_kind = K500;
      else if (eject100 && !p100) ev_kind = K100;
      else if (done && !pdone) ev_kind = KDONE;
      if (ev_kind >= 0) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got kind=%0d remaining=%0d, required no event", ev_kind, remaining);
        end else begin
          ev = sb.pop_front();
          if (ev.kind != ev_kind || int'(remaining) != ev.rem) begin
            failures++;
            $display("FAIL payout_event: got kind=%0d remaining=%0d, required kind=%0d remaining=%0d",
                     ev_kind, remaining, ev.kind, ev.rem);
          end
        end
      end
      if ((eject500 && !p500) || (eject100 && !p100)) pulse_ticks = 0;
      if ((eject500 || eject100) && tick) pulse_ticks++;
      if (!eject500 && !eject100 && (p500 || p100)) begin
        checks++;
        if (pulse_ticks != PT) begin
          failures++;
          $display("FAIL pulse_length: got %0d ticks, required %0d", pulse_ticks, PT);
        end
      end
      if (done && pdone) begin
        checks++;
        failures++;
        $display("FAIL done_width: done high 2 cycles, required 1");
      end
    end
    p500  = eject500;
    p100  = eject100;
    pdone = done;
  end

  // Waits (bounded) for the scoreboard to drain; returns cycles waited.
  task automatic wait_drain(output int n);
    n = 0;
    while (sb.size() != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic start_payout(input int amt);
    @(negedge clk);
    amount = W'(amt);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({eject500, eject100, busy, done, err} !== 5'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL reset_state: ej500=%0b ej100=%0b busy=%0b done=%0b err=%0b rem=%0d, required all 0",
               eject500, eject100, busy, done, err, remaining);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_payout_mixed();
    int n;
    sb.push_back('{K500, 3});
    sb.push_back('{K100, 2});
    sb.push_back('{K100, 1});
    sb.push_back('{K100, 0});
    sb.push_back('{KDONE, 0});
    start_payout(8);
    checks++;
    if (busy !== 1'b1 || remaining !== W'(8)) begin
      failures++;
      $display("FAIL mixed_accept: busy=%0b rem=%0d, required busy=1 rem=8", busy, remaining);
    end
    wait_drain(n);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL mixed_drain: %0d events pending after %0d cycles, required 0", sb.size(), n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL mixed_idle: busy=%0b done=%0b rem=%0d, required 0 0 0", busy, done, remaining);
    end
  endtask

  task automatic test_zero_amount();
    sb.push_back('{KDONE, 0});
    @(negedge clk);
    amount = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL zero_cycle1: done=%0b busy=%0b, required done=0 busy=1", done, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL zero_done_latency: done=%0b at cycle 2, required 1", done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL zero_idle: busy=%0b pending=%0d, required busy=0 pending=0", busy, sb.size());
    end
  endtask

  task automatic test_over_range();
    start_payout(12);
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || remaining !== W'(12)) begin
      failures++;
      $display("FAIL over_fault: err=%0b busy=%0b rem=%0d, required err=1 busy=1 rem=12", err, busy, remaining);
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (err !== 1'b0 || busy !== 1'b0 || remaining !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL over_ack: err=%0b busy=%0b rem=%0d done=%0b, required all 0", err, busy, remaining, done);
    end
  endtask

  task automatic test_empty500_fallback();
    int n;
    empty500 = 1'b1;
    for (int i = 5; i >= 0; i--) sb.push_back('{K100, i});
    sb.push_back('{KDONE, 0});
    start_payout(6);
    wait_drain(n);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL fallback_drain: %0d events pending after %0d cycles, required 0", sb.size(), n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL fallback_idle: busy=%0b rem=%0d, required 0 0", busy, remaining);
    end
    empty500 = 1'b0;
  endtask

  task automatic test_empty100_fault();
    int n;
    sb.push_back('{K100, 2});
    @(negedge clk);
    amount = W'(3);
    start  = 1'b1;
    n = 0;
    while (!eject100 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (eject100 !== 1'b1) begin
      failures++;
      $display("FAIL e100_first_pulse: eject100=%0b after %0d cycles, required 1", eject100, n);
    end
    empty100 = 1'b1;
    n = 0;
    while (!err && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (err !== 1'b1 || busy !== 1'b1 || remaining !== W'(2)) begin
      failures++;
      $display("FAIL e100_fault: err=%0b busy=%0b rem=%0d, required err=1 busy=1 rem=2", err, busy, remaining);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (err !== 1'b1 || remaining !== W'(2) || sb.size() != 0) begin
      failures++;
      $display("FAIL e100_start_ignored: err=%0b rem=%0d pending=%0d, required err=1 rem=2 pending=0",
               err, remaining, sb.size());
    end
    start = 1'b0;
    ack   = 1'b1;
    @(negedge clk);
    ack      = 1'b0;
    empty100 = 1'b0;
    checks++;
    if (err !== 1'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL e100_ack: err=%0b rem=%0d, required 0 0", err, remaining);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int n;
    sb.push_back('{K500, 2});
    start_payout(7);
    n = 0;
    while (!eject500 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (eject500 !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pulse_start: eject500=%0b after %0d cycles, required 1", eject500, n);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (eject500 !== 1'b0 || busy !== 1'b0 || remaining !== '0) begin
      failures++;
      $display("FAIL rst_async: ej500=%0b busy=%0b rem=%0d, required 0 0 0", eject500, busy, remaining);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.push_back('{K100, 1});
    sb.push_back('{K100, 0});
    sb.push_back('{KDONE, 0});
    start_payout(2);
    wait_drain(n);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL rst_restart_drain: %0d events pending after %0d cycles, required 0", sb.size(), n);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL rst_restart_idle: busy=%0b err=%0b, required 0 0", busy, err);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    amount   = '0;
    empty500 = 1'b0;
    empty100 = 1'b0;
    ack      = 1'b0;
    test_reset();
    test_payout_mixed();
    test_zero_amount();
    test_over_range();
    test_empty500_fallback();
    test_empty100_fault();
    test_reset_mid_pulse();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
